// File: rtl/display_pkg.sv
// Shared constants and the 7-segment decoder for the multi-digit display.
// Segment order is {g,f,e,d,c,b,a}, active-low.
package display_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    // BCD nibble to segment pattern; non-decimal nibbles stay dark.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'd0:    pat = SEG_0;
            4'd1:    pat = SEG_1;
            4'd2:    pat = SEG_2;
            4'd3:    pat = SEG_3;
            4'd4:    pat = SEG_4;
            4'd5:    pat = SEG_5;
            4'd6:    pat = SEG_6;
            4'd7:    pat = SEG_7;
            4'd8:    pat = SEG_8;
            4'd9:    pat = SEG_9;
            default: pat = SEG_BLANK;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/multi_digit_display_bin2bcd_seq.sv
// Sequential double-dabble converter: one input bit per cycle.
// done pulses for one cycle when bcd/ovf hold the final result.
module bin2bcd_seq #(
    parameter int VALUE_W    = 14,
    parameter int NUM_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [VALUE_W-1:0]      bin,
    output logic                    busy,
    output logic                    done,
    output logic [4*NUM_DIGITS-1:0] bcd,
    output logic                    ovf
);

    localparam int BW = 4 * NUM_DIGITS;
    localparam int CW = $clog2(VALUE_W + 1);

    logic              r_busy;
    logic              r_done;
    logic              r_ovf;
    logic [BW-1:0]     r_acc;
    logic [VALUE_W-1:0] r_bin;
    logic [CW-1:0]     r_cnt;
    logic [BW-1:0]     w_adj;

    // Add-3 correction applied to every nibble before the shift.
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_adj
            assign w_adj[gi*4 +: 4] = (r_acc[gi*4 +: 4] >= 4'd5) ?
                                      (r_acc[gi*4 +: 4] + 4'd3) : r_acc[gi*4 +: 4];
        end
    endgenerate

    // Capture on start, then shift one bit per cycle; a 1 leaving the top nibble is sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_ovf  <= 1'b0;
            r_acc  <= '0;
            r_bin  <= '0;
            r_cnt  <= '0;
        end else begin
            r_done <= 1'b0;
            if (!r_busy) begin
                if (start) begin
                    r_busy <= 1'b1;
                    r_bin  <= bin;
                    r_acc  <= '0;
                    r_ovf  <= 1'b0;
                    r_cnt  <= '0;
                end
            end else begin
                r_acc <= {w_adj[BW-2:0], r_bin[VALUE_W-1]};
                r_ovf <= r_ovf | w_adj[BW-1];
                r_bin <= r_bin << 1;
                r_cnt <= r_cnt + 1'b1;
                if (r_cnt == CW'(VALUE_W - 1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign bcd  = r_acc;
    assign ovf  = r_ovf;

endmodule

// File: rtl/multi_digit_display.sv
// Multi-digit common-anode 7-segment driver with load/busy handshake,
// sequential binary-to-BCD conversion, per-slot dead time and overflow dashes.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 never).
import display_pkg::*;

module multi_digit_display #(
    parameter int NUM_DIGITS  = 4,
    parameter int VALUE_W     = 14,
    parameter int REFRESH_DIV = 25000,
    parameter int DEAD_CYC    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [VALUE_W-1:0]    value,
    input  logic                  load,
    output logic                  busy,
    output logic                  overflow,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] an
);

    localparam int BW = 4 * NUM_DIGITS;
    localparam int SW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic                  r_busy;
    logic                  r_overflow;
    logic [BW-1:0]         r_disp;
    logic [SW-1:0]         r_slot;
    logic [IW-1:0]         r_idx;
    logic [6:0]            r_seg;
    logic [NUM_DIGITS-1:0] r_an;

    logic                  w_accept;
    logic                  w_eng_busy;
    logic                  w_eng_done;
    logic                  w_eng_ovf;
    logic [BW-1:0]         w_eng_bcd;
    logic [6:0]            w_digit_seg [NUM_DIGITS];

    assign w_accept = load & ~r_busy & ~w_eng_busy;

    bin2bcd_seq #(
        .VALUE_W    (VALUE_W),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (w_accept),
        .bin   (value),
        .busy  (w_eng_busy),
        .done  (w_eng_done),
        .bcd   (w_eng_bcd),
        .ovf   (w_eng_ovf)
    );

    // Segment pattern each digit would show in its active window.
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            logic w_blank;
`ifdef LEADING_ZERO_BLANK_EN
            assign w_blank = (gi != 0) && (r_disp[BW-1:gi*4] == '0);
`else
            assign w_blank = 1'b0;
`endif
            assign w_digit_seg[gi] = r_overflow ? SEG_DASH :
                                     (w_blank ? SEG_BLANK : seg_decode(r_disp[gi*4 +: 4]));
        end
    endgenerate

    // Handshake: busy from acceptance until the result is committed; digits and overflow swap together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy     <= 1'b0;
            r_overflow <= 1'b0;
            r_disp     <= '0;
        end else if (w_accept) begin
            r_busy <= 1'b1;
        end else if (w_eng_done) begin
            r_busy     <= 1'b0;
            r_disp     <= w_eng_bcd;
            r_overflow <= w_eng_ovf;
        end
    end

    // Refresh timebase: slot counter wraps every REFRESH_DIV cycles and advances the digit index.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot <= '0;
            r_idx  <= '0;
        end else if (r_slot == SW'(REFRESH_DIV - 1)) begin
            r_slot <= '0;
            r_idx  <= (r_idx == IW'(NUM_DIGITS - 1)) ? '0 : r_idx + 1'b1;
        end else begin
            r_slot <= r_slot + 1'b1;
        end
    end

    // Registered pin drive: dark during the dead window at the start of each slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_an  <= '1;
            r_seg <= SEG_BLANK;
        end else if (r_slot < SW'(DEAD_CYC)) begin
            r_an  <= '1;
            r_seg <= SEG_BLANK;
        end else begin
            r_an  <= ~(NUM_DIGITS'(1) << r_idx);
            r_seg <= w_digit_seg[r_idx];
        end
    end

    assign busy     = r_busy;
    assign overflow = r_overflow;
    assign seg      = r_seg;
    assign an       = r_an;

endmodule

// File: tb/tb_multi_digit_display.sv
// Scoreboard bench for multi_digit_display (4 digits, 14-bit value, 8-cycle slots, 2 dead cycles).
module tb_multi_digit_display;

    localparam int ND   = 4;
    localparam int VW   = 14;
    localparam int RD   = 8;
    localparam int DC   = 2;
    localparam int MAXV = 9999;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [VW-1:0] value = '0;
    logic          load = 1'b0;
    logic          busy;
    logic          overflow;
    logic [6:0]    seg;
    logic [ND-1:0] an;

    multi_digit_display #(
        .NUM_DIGITS  (ND),
        .VALUE_W     (VW),
        .REFRESH_DIV (RD),
        .DEAD_CYC    (DC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .value    (value),
        .load     (load),
        .busy     (busy),
        .overflow (overflow),
        .seg      (seg),
        .an       (an)
    );

    always #5 clk = ~clk;

    typedef struct {
        int v;
        bit chk_busy;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   done_cnt = 0;
    int   issued = 0;
    bit   scan_req = 1'b0;
    int   cyc = 0;

    logic [6:0] tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                             7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    // Clock edges with reset low since the last reset edge.
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    // Reference: what digit idx should show for a committed value.
    function automatic logic [6:0] exp_digit(input int v, input int idx);
        int p = 1;
        for (int k = 0; k < idx; k++) p = p * 10;
        if (v > MAXV) return 7'h3F;
`ifdef LEADING_ZERO_BLANK_EN
        if (idx > 0 && v < p) return 7'h7F;
`endif
        return tbl[(v / p) % 10];
    endfunction

    // Monitor: on each completed conversion (or explicit request) pop and check a whole frame.
    initial begin
        int   blen = 0;
        bit   pb = 1'b0;
        bit   fall;
        exp_t e;
        int   p, slot, idx;
        logic [ND-1:0] ea;
        logic [6:0]    es;
        forever begin
            @(negedge clk);
            fall = pb && !busy && (cyc != 0);
            if (busy) blen++;
            if (fall || scan_req) begin
                scan_req = 1'b0;
                if (q.size() == 0) begin
                    check("unexpected_commit", 1, 0);
                end else begin
                    e = q.pop_front();
                    $display("txn value=%0d busy_cycles=%0d overflow=%0b", e.v, blen, overflow);
                    if (e.chk_busy) check("busy_len", blen, VW + 1);
                    check("overflow", int'(overflow), int'(e.v > MAXV));
                    for (int k = 0; k < ND * RD; k++) begin
                        @(negedge clk);
                        p    = cyc - 1;
                        slot = p % RD;
                        idx  = (p / RD) % ND;
                        if (slot < DC) begin
                            ea = '1;
                            es = 7'h7F;
                        end else begin
                            ea = ~(ND'(1) << idx);
                            es = exp_digit(e.v, idx);
                        end
                        check("an", int'(an), int'(ea));
                        check("seg", int'(seg), int'(es));
                    end
                end
                done_cnt++;
            end
            if (!busy) blen = 0;
            pb = busy;
        end
    end

    task automatic do_load(input int v, input bit accept);
        exp_t e;
        @(negedge clk);
        value = VW'(v);
        load  = 1'b1;
        if (accept) begin
            e.v = v;
            e.chk_busy = 1'b1;
            q.push_back(e);
            issued++;
        end
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic request_scan(input int v);
        exp_t e;
        e.v = v;
        e.chk_busy = 1'b0;
        q.push_back(e);
        issued++;
        @(posedge clk);
        scan_req = 1'b1;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 400 && done_cnt < issued; i++) @(negedge clk);
        if (done_cnt < issued) begin
            check("timeout", done_cnt, issued);
            done_cnt = issued;
            q.delete();
        end
    endtask

    initial begin
        int v;
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_overflow", int'(overflow), 0);
        check("rst_an", int'(an), 4'hF);
        check("rst_seg", int'(seg), 7'h7F);
        rst = 1'b0;
        request_scan(0);
        wait_done();

        // Directed values
        do_load(1234, 1);  wait_done();
        do_load(10000, 1); wait_done();
        do_load(42, 1);    wait_done();
        do_load(7, 1);     wait_done();
        do_load(9999, 1);  wait_done();
        do_load(16383, 1); wait_done();
        do_load(0, 1);     wait_done();

        // Load while busy is dropped
        do_load(5, 1);
        @(negedge clk);
        do_load(9, 0);
        wait_done();
        do_load(9, 1);     wait_done();

        // Reset in the middle of a conversion
        do_load(9999, 0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", int'(busy), 0);
        check("abort_overflow", int'(overflow), 0);
        check("abort_an", int'(an), 4'hF);
        check("abort_seg", int'(seg), 7'h7F);
        rst = 1'b0;
        request_scan(0);
        wait_done();

        // Random values over the full input range
        for (int n = 0; n < 10; n++) begin
            v = int'($urandom_range(0, (1 << VW) - 1));
            do_load(v, 1);
            wait_done();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multi_digit_display.md
Name: multi_digit_display

Overview:
Parametrised successor to the two-digit 7-segment multiplexer. Accepts a binary value through a load/busy handshake and converts it to BCD with a sequential double-dabble engine. Time-multiplexes NUM_DIGITS common-anode digits, with an anti-ghosting dead time at each digit change and overflow indication. Sits between the sensor/CPU register interface and the board display pins.

Parameters:
NUM_DIGITS, 4, number of displayed digits (1-8).
VALUE_W, 14, binary input width (1-27).
REFRESH_DIV, 25000, clock cycles per digit slot (≥ DEAD_CYC+2).
DEAD_CYC, 16, cycles at the start of each slot with all anodes off.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
value  in  VALUE_W  binary value to display
load  in  1  request conversion of value
busy  out  1  conversion in progress; load ignored while high
overflow  out  1  last accepted value exceeded 10^NUM_DIGITS-1
seg  out  7  segments {g,f,e,d,c,b,a}, active-low
an  out  NUM_DIGITS  digit enables, active-low; bit 0 = ones digit

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - busy=0, overflow=0.
  - seg=7'h7F and an=all ones (display dark).
  - Displayed BCD register=0, slot counter=0, digit index=0.
- Handshake:
  - load is sampled only when busy=0. On acceptance, value is captured and busy=1 from the next cycle.
  - load while busy=1 is dropped, with no queueing.
- Conversion:
  - Double dabble over VALUE_W cycles: add-3 to every BCD nibble ≥5, then shift left one bit.
  - The BCD accumulator is 4*NUM_DIGITS bits. Any 1 shifted out of the top nibble sets a sticky ovf_acc.
  - Commit cycle is VALUE_W+1 cycles after acceptance:
    - Displayed BCD and overflow update atomically in the same cycle, so there is no tearing.
    - busy falls on the following cycle. Total busy time is VALUE_W+1 cycles.
  - A new load is accepted on the first cycle busy=0.
- Refresh:
  - slot_cnt counts 0..REFRESH_DIV-1 and wraps.
  - On wrap, digit index increments 0..NUM_DIGITS-1, then wraps to 0.
- Output, registered with 1-cycle latency from slot_cnt/index:
  - slot_cnt < DEAD_CYC: an=all ones, seg=7'h7F.
  - Otherwise: an = ~(1<<index), seg = decode(nibble[index]).
- Decode (active-low {g..a}), 0-9 only:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex).
  - Other nibbles give 7F.
- Overflow display: while overflow=1, every non-dead digit shows a dash, seg=7'h3F.
- Value update mid-slot: the new digits appear on the next registered output. No slot restart.
- Reset mid-conversion: aborts the conversion and returns everything to reset values, including a dark display.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: a digit i>0 is blanked (seg=7'h7F, anode still driven) when it and all higher nibbles are zero. Digit 0 is never blanked, so value 0 shows "0". Blanking does not apply while overflow=1.
- Undefined: all digits show zero-padded values, e.g. "0007".

Decomposition:
- Shared package display_pkg holds:
  - the SEG_* digit constants,
  - SEG_BLANK=7'h7F and SEG_DASH=7'h3F,
  - a seg_decode function.
- Sub-module bin2bcd_seq (parameters VALUE_W, NUM_DIGITS; ports clk, rst, start, bin, busy, done, bcd, ovf) holds the double-dabble engine. The top level contains the handshake, refresh counter, dead time and output registers.

Test Plan:
- Conversion and timing (REFRESH_DIV=8, DEAD_CYC=2): load value=1234. busy stays high 15 cycles, overflow=0. Over 4 slots, an cycles E,D,B,7 with seg 19,30,24,79; an=F/seg=7F for the first 2 cycles of each slot.
- Overflow: load 10000 → overflow=1 and all digits 3F. Then load 42 → overflow=0 and digits 0,0,4,2.
- Leading-zero blanking, value=7:
  - LEADING_ZERO_BLANK_EN defined: digits 3..1 seg=7F, digit 0 seg=78.
  - Undefined: digits 3..1 seg=40.
- Load while busy: load 5, then load 9 two cycles later → display 5. Load 9 again after busy falls → display 9.
- Reset mid-conversion: rst asserted 5 cycles after load of 9999 → next cycle busy=0, an=F, seg=7F, and later digits all 0 (value 0).
